// File: rtl/fp_sqrt_iter_if.sv
// fp_sqrt_iter_if: request/response bundle for the iterative square-root unit
//   master drives : En_i, Kill_i, OpA_i, Tag_i, Rnd_i
//   slave drives  : Res_o, Status_o, Tag_o, Valid_o, Ready_o
interface fp_sqrt_iter_if #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 23,
    parameter int TAG_WIDTH = 4
);
    localparam int W = 1 + EXP_WIDTH + SIG_WIDTH;
    logic                 En_i;
    logic                 Kill_i;
    logic [W-1:0]         OpA_i;
    logic [TAG_WIDTH-1:0] Tag_i;
    logic [2:0]           Rnd_i;
    logic [W-1:0]         Res_o;
    logic [4:0]           Status_o;
    logic [TAG_WIDTH-1:0] Tag_o;
    logic                 Valid_o;
    logic                 Ready_o;
    modport master (
        output En_i, Kill_i, OpA_i, Tag_i, Rnd_i,
        input  Res_o, Status_o, Tag_o, Valid_o, Ready_o
    );
    modport slave (
        input  En_i, Kill_i, OpA_i, Tag_i, Rnd_i,
        output Res_o, Status_o, Tag_o, Valid_o, Ready_o
    );
endinterface

// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: iterative IEEE-754 square root using a restoring digit recurrence
//   clk_i  : clock, all flops on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : fp_sqrt_iter_if.slave (En_i/Kill_i/OpA_i/Tag_i/Rnd_i in,
//            Res_o/Status_o/Tag_o/Valid_o/Ready_o out)
//   FP_SQRT_DENORM_EN : when defined, subnormal operands are normalised at accept;
//            otherwise they are flushed to a zero of the same sign.
module fp_sqrt_iter #(
    parameter int EXP_WIDTH      = 8,
    parameter int SIG_WIDTH      = 23,
    parameter int TAG_WIDTH      = 4,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic           clk_i,
    input logic           rst_ni,
    fp_sqrt_iter_if.slave bus
);
    localparam int W    = 1 + EXP_WIDTH + SIG_WIDTH;
    localparam int N    = (SIG_WIDTH + 1 + BITS_PER_CYCLE) / BITS_PER_CYCLE;
    // root bits: integer 1, fraction, guard, and one surplus bit when N*BPC overshoots
    localparam int R    = N * BITS_PER_CYCLE;
    localparam int LOW  = R - SIG_WIDTH - 1;
    localparam int CW   = $clog2(N + 1);
    localparam int EW   = EXP_WIDTH + 2;
    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};

    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bpc_check
        $error("BITS_PER_CYCLE must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, ITER, ROUND} state_t;
    state_t state, state_n;

    logic [CW-1:0]        cnt;
    logic [2*R-1:0]       rad, rad_n, rad_in;
    logic [R+1:0]         rem, rem_n, shifted, trial;
    logic [R-1:0]         q, q_n;
    logic [EXP_WIDTH-1:0] exp_r, exp_in, e_in;
    logic [2:0]           rnd;
    logic [TAG_WIDTH-1:0] tag;
    logic                 special, special_in, nv_r, nv_in;
    logic [W-1:0]         spec_r, spec_in, rnd_res;
    logic                 sgn, e_max, e_zero, f_zero, is_zero, guard, sticky, up;
    logic [SIG_WIDTH-1:0] f_in, mant;
    logic [SIG_WIDTH:0]   sig_n, sum;
    logic signed [EW-1:0] eu;
    logic [LOW-1:0]       low;

    assign sgn    = bus.OpA_i[W-1];
    assign e_in   = bus.OpA_i[W-2 -: EXP_WIDTH];
    assign f_in   = bus.OpA_i[SIG_WIDTH-1:0];
    assign e_max  = &e_in;
    assign e_zero = ~|e_in;
    assign f_zero = ~|f_in;

`ifdef FP_SQRT_DENORM_EN
    localparam int LW = $clog2(SIG_WIDTH + 2);
    logic [LW-1:0] lzc;
    // leading zeros of {0, fraction}; the highest set bit wins
    always_comb begin
        lzc = '0;
        for (int i = 0; i < SIG_WIDTH; i++) lzc = f_in[i] ? LW'(SIG_WIDTH - i) : lzc;
    end
    assign is_zero = e_zero & f_zero;
    assign sig_n   = e_zero ? {1'b0, f_in} << lzc : {1'b1, f_in};
    assign eu      = e_zero ? EW'(1 - BIAS) - EW'(lzc) : EW'(e_in) - EW'(BIAS);
`else
    assign is_zero = e_zero;
    assign sig_n   = {1'b1, f_in};
    assign eu      = EW'(e_in) - EW'(BIAS);
`endif

    // odd exponents fold one factor of two into the radicand so the root stays in [1,2)
    assign rad_in     = {eu[0] ? {sig_n, 1'b0} : {1'b0, sig_n}, {(2*R-2-SIG_WIDTH){1'b0}}};
    assign exp_in     = EXP_WIDTH'((eu >>> 1) + EW'(BIAS));
    assign special_in = e_max | is_zero | sgn;
    assign spec_in    = is_zero ? {sgn, {(W-1){1'b0}}} :
                        (sgn | ~f_zero) ? QNAN : {1'b0, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
    assign nv_in      = (e_max & ~f_zero) ? ~f_in[SIG_WIDTH-1] : sgn & ~is_zero;

    always_comb begin
        rem_n   = rem;
        q_n     = q;
        rad_n   = rad;
        shifted = '0;
        trial   = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted = {rem_n[R-1:0], rad_n[2*R-1 -: 2]};
            trial   = {q_n, 2'b01};
            rem_n   = shifted >= trial ? shifted - trial : shifted;
            q_n     = {q_n[R-2:0], shifted >= trial};
            rad_n   = rad_n << 2;
        end
    end

    // the result is always positive, so RDN rounds like RTZ and RUP rounds away
    assign mant    = q[R-2:LOW];
    assign low     = q[LOW-1:0];
    assign guard   = low[LOW-1];
    assign sticky  = (|(low << 1)) | (|rem);
    assign up      = (rnd == 3'b001 || rnd == 3'b010) ? 1'b0 :
                     rnd == 3'b011 ? guard | sticky :
                     rnd == 3'b100 ? guard : guard & (sticky | mant[0]);
    assign sum     = {1'b0, mant} + (SIG_WIDTH+1)'(up);
    assign rnd_res = {1'b0, exp_r + EXP_WIDTH'(sum[SIG_WIDTH]), sum[SIG_WIDTH-1:0]};

    assign bus.Ready_o = state == IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (bus.En_i ? (special_in ? ROUND : ITER) : IDLE) :
                  (state == ITER && !bus.Kill_i) ? (cnt == '0 ? ROUND : ITER) : IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt          <= '0;
            rad          <= '0;
            rem          <= '0;
            q            <= '0;
            exp_r        <= '0;
            rnd          <= '0;
            tag          <= '0;
            special      <= 1'b0;
            spec_r       <= '0;
            nv_r         <= 1'b0;
            bus.Res_o    <= '0;
            bus.Status_o <= '0;
            bus.Tag_o    <= '0;
            bus.Valid_o  <= 1'b0;
        end else begin
            bus.Valid_o <= 1'b0;
            if (state == IDLE && bus.En_i) begin
                cnt     <= CW'(N - 1);
                rad     <= rad_in;
                rem     <= '0;
                q       <= '0;
                exp_r   <= exp_in;
                rnd     <= bus.Rnd_i;
                tag     <= bus.Tag_i;
                special <= special_in;
                spec_r  <= spec_in;
                nv_r    <= nv_in;
            end else if (state == ITER) begin
                cnt <= cnt - CW'(1);
                rad <= rad_n;
                rem <= rem_n;
                q   <= q_n;
            end else if (state == ROUND && !bus.Kill_i) begin
                bus.Valid_o  <= 1'b1;
                bus.Res_o    <= special ? spec_r : rnd_res;
                bus.Status_o <= special ? {nv_r, 4'b0000} : {4'b0000, guard | sticky};
                bus.Tag_o    <= tag;
            end
        end
    end
endmodule

// File: doc/fp_sqrt_iter.md
# fp_sqrt_iter

Parametrised iterative IEEE-754 square-root unit for the shared APU; a multi-cycle successor to the single-cycle sqrt wrapper. It computes a digit-recurrence root over a configurable number of bits per cycle and supports any EXP_WIDTH/SIG_WIDTH format. It implements all five RISC-V rounding modes and returns IEEE status flags. It exposes a ready/valid handshake with tag passthrough and an abort input, and sits in the APU cluster's sqrt slot.

## Interface
- EXP_WIDTH, 8: exponent width.
- SIG_WIDTH, 23: stored mantissa width; FP width W = 1+EXP_WIDTH+SIG_WIDTH.
- TAG_WIDTH, 4: tag width, ≥1.
- BITS_PER_CYCLE, 1: root bits per iteration, 1 or 2 only; elaboration error otherwise.
- clk_i  in  1  clock, all flops posedge.
- rst_ni  in  1  reset, asynchronous, active-low.
- En_i  in  1  operation request; accepted on an edge where En_i & Ready_o.
- Kill_i  in  1  synchronous abort of the in-flight operation.
- OpA_i  in  W  operand.
- Tag_i  in  TAG_WIDTH  tag, captured on accept.
- Rnd_i  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE.
- Res_o  out  W  result, registered.
- Status_o  out  5  {NV, DZ, OF, UF, NX}, registered.
- Tag_o  out  TAG_WIDTH  tag of Res_o, registered.
- Valid_o  out  1  one-cycle pulse, Res_o/Status_o/Tag_o valid.
- Ready_o  out  1  high while state == IDLE.

## Operation
- States: IDLE, ITER, ROUND.
- IDLE + accept, normal operand:
  - Unpack the operand; capture Tag_i and Rnd_i.
  - Radicand is {1,mantissa}, left-shifted one extra if the unbiased exponent is odd.
  - Load the iteration counter with N−1, where N = ceil((SIG_WIDTH+2)/BITS_PER_CYCLE); go to ITER.
- IDLE + accept, special operand: preload the result and flags, then go directly to ROUND.
  - NaN → canonical qNaN (0x7FC00000 for single); NV set only for sNaN.
  - Negative nonzero, including −inf → canonical qNaN, NV.
  - ±0 → ±0, no flags.
  - +inf → +inf, no flags.
- ITER:
  - Each edge runs a restoring recurrence step, producing BITS_PER_CYCLE root bits from a remainder of SIG_WIDTH+4 bits.
  - The counter decrements; when it reaches 0, go to ROUND.
- ROUND:
  - Root is 1.f plus a guard bit; sticky = (remainder ≠ 0) | any discarded bits.
  - Result sign is always +, so RDN behaves as RTZ and RUP increments when inexact.
  - RNE/RMM use the guard bit and sticky.
  - A mantissa carry-out increments the exponent.
  - Result exponent = ((e_biased − bias) >>> 1) + bias, computed in signed EXP_WIDTH+2 arithmetic.
  - NX = guard | sticky; OF, UF and DZ are always 0.
  - Register Res_o, Status_o and Tag_o; pulse Valid_o; go to IDLE.
- Kill_i:
  - In ITER or ROUND it forces IDLE, and no Valid_o is produced for the killed operation.
  - Kill_i in IDLE is ignored.
  - Kill_i and En_i together in IDLE: the accept proceeds.
- En_i while Ready_o is low is ignored; there is no queueing.
- Outputs hold their last values between Valid_o pulses.

## Timing
- Reset:
  - State = IDLE, so Ready_o = 1.
  - Valid_o = 0; Res_o, Status_o and Tag_o = 0.
  - All datapath registers are cleared.
- Accept on edge k, normal operand:
  - ITER runs on edges k+1…k+N.
  - ROUND is on edge k+N+1.
  - Valid_o is high for the one cycle after edge k+N+1.
  - Single precision, BITS_PER_CYCLE=1 gives N=25.
- Accept on edge k, special operand: Valid_o is high for the one cycle after edge k+1.
- Ready_o rises in the same cycle as Valid_o, so a new accept on that edge is legal. Throughput is one operation per N+2 cycles.
- Reset asserted mid-operation: immediately returns to the reset state; the pending result is lost.

## Configuration
- FP_SQRT_DENORM_EN defined:
  - Subnormal inputs are normalised with a leading-zero count and left shift at accept.
  - The effective exponent is 1−bias−lzc.
  - Latency is unchanged.
- Not defined: subnormal inputs are treated as zero of the same sign, with no flags, and take the special path.
- The result is never subnormal in either build.

## Test plan
- 0x40800000, RNE, accept on edge k → Res_o 0x40000000, Status_o 0, Valid_o high only in the cycle after edge k+26; Tag_i value is echoed on Tag_o.
- 0x40000000, RNE → 0x3FB504F3, NX=1.
- 0x40000000, RUP → 0x3FB504F4, NX=1.
- 0x40000000, RTZ → 0x3FB504F3, NX=1.
- Specials, each with Valid_o in the cycle after edge k+1:
  - 0xBF800000 → 0x7FC00000, NV.
  - 0x80000000 → 0x80000000, no flags.
  - 0x7F800000 → 0x7F800000, no flags.
  - 0x7F800001 → 0x7FC00000, NV.
- Back-to-back: second En_i asserted in the Valid_o cycle of the first → second is accepted on that edge, second Valid_o follows 26 edges later.
- En_i asserted while busy → ignored, exactly one Valid_o.
- Kill_i asserted on edge k+10 → no Valid_o, Ready_o=1 after edge k+10.
- Reset pulse mid-ITER → all outputs 0, Ready_o=1.
- 0x00400000, RNE:
  - With FP_SQRT_DENORM_EN → 0x1FB504F3, NX=1.
  - Without → 0x00000000, no flags, Valid_o in the cycle after edge k+1.
